// File: rtl/keypad_pkg.sv
// Shared constants and decode helpers for the keypad / display block.
// Key codes, blank nibble, segment and one-hot decoders.
package keypad_pkg;

  localparam logic [3:0] KEY_BS  = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [3:0] BLANK   = 4'hF;

  typedef enum logic {
    DB_DISARMED,
    DB_ARMED
  } db_state_e;

  // Active-high {g,f,e,d,c,b,a}; anything not 0-9 is dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] onehot_code(input logic [11:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < 12; k++) begin
      if (v[k]) c = 4'(k);
    end
    return c;
  endfunction

  function automatic logic is_onehot(input logic [11:0] v);
    return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Two-flop synchroniser plus one-hot debounce with release re-arm.
// Emits a single-cycle key_valid and holds the accepted code.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] keys,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  logic [11:0] sync1;
  logic [11:0] sync2;
  db_state_e   state_q;
  db_state_e   state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [3:0]  cand_q;
  logic [3:0]  cand_d;
  logic        valid_q;
  logic        valid_d;
  logic [3:0]  code_q;
  logic [3:0]  code_d;
  logic        single;
  logic        idle;
  logic        last;
  logic [3:0]  code_now;

  // Synchroniser keeps sampling through reset so a held key is
  // already visible (and blocks arming) when reset lifts.
  always_ff @(posedge clk) begin
    sync1 <= keys;
    sync2 <= sync1;
  end

  assign single   = is_onehot(sync2);
  assign idle     = (sync2 == 12'd0);
  assign last     = (cnt_q == DEBOUNCE_CYC - 16'd1);
  assign code_now = onehot_code(sync2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DB_DISARMED;
      cnt_q   <= '0;
      cand_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    valid_d = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      DB_DISARMED: begin
        if (idle) begin
          if (last) begin
            state_d = DB_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      DB_ARMED: begin
        if (single) begin
          if (cnt_q != 16'd0 && code_now == cand_q) begin
            if (last) begin
              valid_d = 1'b1;
              code_d  = code_now;
              state_d = DB_DISARMED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end else begin
            cand_d = code_now;
            cnt_d  = 16'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = DB_DISARMED;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

// File: rtl/keypad_display_multi.sv
// N-digit keypad entry buffer with multiplexed 7-segment scan.
// Digit 0 is the rightmost; new digits enter from the right.
module keypad_display_multi
  import keypad_pkg::*;
#(
  parameter int          N_DIGITS       = 8,
  parameter logic [15:0] DEBOUNCE_CYC   = 16'd50000,
  parameter logic [15:0] SCAN_DIV       = 16'd10000,
  parameter int          ENTRY_MODE     = 0,
  parameter int          COM_ACTIVE_LOW = 1,
  parameter int          SEG_ACTIVE_LOW = 0
) (
  input  logic                            iCLK,
  input  logic                            nRST,
  input  logic [11:0]                     iKeypad,
  output logic [N_DIGITS-1:0]             oS_COM,
  output logic [7:0]                      oS_ENS,
  output logic                            oKeyValid,
  output logic [3:0]                      oKeyCode,
  output logic [$clog2(N_DIGITS+1)-1:0]   oCount,
  output logic                            oOverflow
);

  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] FULL = CW'(N_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] COM_OFF =
    (COM_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic                key_valid;
  logic [3:0]          key_code;
  logic [3:0]          dig_q [N_DIGITS];
  logic [3:0]          dig_d [N_DIGITS];
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic                ovf_q;
  logic                ovf_d;
  logic                is_digit;
  logic                full;
  logic [IW-1:0]       idx_q;
  logic [15:0]         div_q;
  logic [N_DIGITS-1:0] sel;
  logic [7:0]          seg;
  logic [N_DIGITS-1:0] com_q;
  logic [7:0]          ens_q;

  keypad_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk       (iCLK),
    .rst_n     (nRST),
    .keys      (iKeypad),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  assign is_digit = (key_code <= 4'd9);
  assign full     = (count_q == FULL);

  always_comb begin
    dig_d   = dig_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unique case (1'b1)
      key_valid && is_digit && (!full || ENTRY_MODE != 0): begin
        for (int i = N_DIGITS - 1; i > 0; i--) dig_d[i] = dig_q[i-1];
        dig_d[0] = key_code;
        count_d  = full ? count_q : count_q + 1'b1;
      end
      key_valid && is_digit && full && ENTRY_MODE == 0: begin
        ovf_d = 1'b1;
      end
      key_valid && key_code == KEY_BS && count_q != '0: begin
        for (int i = 0; i < N_DIGITS - 1; i++) dig_d[i] = dig_q[i+1];
        dig_d[N_DIGITS-1] = BLANK;
        count_d = count_q - 1'b1;
      end
      key_valid && key_code == KEY_CLR: begin
        for (int i = 0; i < N_DIGITS; i++) dig_d[i] = BLANK;
        count_d = '0;
      end
      default: ;
    endcase
  end

  // Select and segments come from the same registered index, so the
  // scan reads the buffer as it was before any same-cycle update.
  always_comb begin
    sel = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    seg = {1'b0, seg7(dig_q[idx_q])};
  end

  always_ff @(posedge iCLK) begin
    if (!nRST) begin
      for (int i = 0; i < N_DIGITS; i++) dig_q[i] <= BLANK;
      count_q <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      div_q   <= '0;
      com_q   <= COM_OFF;
      ens_q   <= SEG_OFF;
    end else begin
      dig_q   <= dig_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (div_q == SCAN_DIV - 16'd1) begin
        div_q <= '0;
        idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 16'd1;
      end
      com_q <= (COM_ACTIVE_LOW != 0) ? ~sel : sel;
      ens_q <= (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    end
  end

  assign oS_COM    = com_q;
  assign oS_ENS    = ens_q;
  assign oKeyValid = key_valid;
  assign oKeyCode  = key_code;
  assign oCount    = count_q;
  assign oOverflow = ovf_q;

endmodule
